// File: rtl/fwrisc_fd_pkg.sv
// Shared widths, entry layout and count-width helper for the fetch/decode buffer.
package fwrisc_fd_pkg;

    localparam int FWRISC_INSTR_W = 32;
    localparam int FWRISC_PC_W    = 32;

    typedef struct packed {
        logic [FWRISC_INSTR_W-1:0] instr;
        logic                      instr_c;
        logic [FWRISC_PC_W-1:0]    pc;
    } fd_entry_t;

    function automatic int fd_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwrisc_fd_buf_mem.sv
// DEPTH x W register array: one write port, one asynchronous read port, async active-low clear.
module fwrisc_fd_buf_mem #(
    parameter int W     = 65,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fwrisc_fd_pipe_buf.sv
// Fetch-to-decode pipeline buffer: DEPTH-entry circular queue of {instr, instr_c, pc}.
// Define FWRISC_FD_PIPE_BYPASS_EN for a zero-latency pass-through when the buffer is empty.
module fwrisc_fd_pipe_buf
    import fwrisc_fd_pkg::*;
#(
    parameter int INSTR_W = FWRISC_INSTR_W,
    parameter int PC_W    = FWRISC_PC_W,
    parameter int DEPTH   = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        fetch_valid_f,
    output logic                        fetch_ready_f,
    input  logic [INSTR_W-1:0]          instr_f,
    input  logic                        instr_c_f,
    input  logic [PC_W-1:0]             pc_f,
    output logic                        fetch_valid_d,
    input  logic                        decode_ready_d,
    output logic [INSTR_W-1:0]          instr_d,
    output logic                        instr_c_d,
    output logic [PC_W-1:0]             pc_d,
    output logic [fd_cnt_w(DEPTH)-1:0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = fd_cnt_w(DEPTH);
    localparam int EW = INSTR_W + 1 + PC_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, bypass, push, pop, mem_wr, mem_rd;
    logic [EW-1:0] wr_data, head, head_out;

    // Handshake: a transfer occurs on an edge where valid and ready are both high and
    // flush is low; valid never waits on ready, and fetch_ready_f depends on count_q only.
    assign empty         = (count_q == '0);
    assign fetch_ready_f = (count_q != FULL_CNT);
`ifdef FWRISC_FD_PIPE_BYPASS_EN
    assign bypass = empty & fetch_valid_f & ~flush;
`else
    assign bypass = 1'b0;
`endif
    assign fetch_valid_d = ~empty | bypass;
    assign push          = fetch_valid_f & fetch_ready_f & ~flush;
    assign pop           = fetch_valid_d & decode_ready_d & ~flush;
    // A bypassed entry taken by decode never touches storage.
    assign mem_wr        = push & ~(bypass & decode_ready_d);
    assign mem_rd        = pop & ~empty;
    assign wr_data       = {instr_f, instr_c_f, pc_f};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (mem_wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (mem_rd) rd_ptr_d = rd_ptr_q + AW'(1);
            if (mem_wr && !mem_rd) begin
                count_d = count_q + CW'(1);
            end else if (!mem_wr && mem_rd) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fwrisc_fd_buf_mem #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (mem_wr),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (head)
    );

    always_comb begin
        head_out = '0;
        if (bypass) begin
            head_out = wr_data;
        end else if (!empty) begin
            head_out = head;
        end
    end

    assign instr_d   = head_out[EW-1 -: INSTR_W];
    assign instr_c_d = head_out[PC_W];
    assign pc_d      = head_out[PC_W-1:0];
    assign count     = count_q;

endmodule

// File: tb/tb_fwrisc_fd_pipe_buf.sv
// Directed plus random bench for fwrisc_fd_pipe_buf (DEPTH=4) with a queue scoreboard.
module tb_fwrisc_fd_pipe_buf;
    import fwrisc_fd_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = fd_cnt_w(DEPTH);
    localparam int EW    = $bits(fd_entry_t);

    logic          clock;
    logic          reset_n;
    logic          flush;
    logic          fetch_valid_f;
    logic          fetch_ready_f;
    logic [31:0]   instr_f;
    logic          instr_c_f;
    logic [31:0]   pc_f;
    logic          fetch_valid_d;
    logic          decode_ready_d;
    logic [31:0]   instr_d;
    logic          instr_c_d;
    logic [31:0]   pc_d;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_err = 0;
    int m_cnt = 0;
    string phase = "init";
    logic [EW-1:0] exp_q[$];

    fwrisc_fd_pipe_buf #(
        .INSTR_W (32),
        .PC_W    (32),
        .DEPTH   (DEPTH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .flush          (flush),
        .fetch_valid_f  (fetch_valid_f),
        .fetch_ready_f  (fetch_ready_f),
        .instr_f        (instr_f),
        .instr_c_f      (instr_c_f),
        .pc_f           (pc_f),
        .fetch_valid_d  (fetch_valid_d),
        .decode_ready_d (decode_ready_d),
        .instr_d        (instr_d),
        .instr_c_d      (instr_c_d),
        .pc_d           (pc_d),
        .count          (count)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s/%s: got %0h exp %0h", phase, tag, got, exp);
        end
    endtask

    // Driver: one clock cycle; checks outputs mid-cycle, then updates the scoreboard model.
    task automatic step(input logic fv, input logic [31:0] ins, input logic c,
                        input logic [31:0] pc, input logic dr, input logic fl);
        logic          m_ready;
        logic          m_valid;
        logic          byp;
        logic          push;
        logic          pop;
        logic [EW-1:0] exp_head;
        fetch_valid_f  = fv;
        instr_f        = ins;
        instr_c_f      = c;
        pc_f           = pc;
        decode_ready_d = dr;
        flush          = fl;
        #2;
        m_ready = (m_cnt != DEPTH);
        byp     = 1'b0;
`ifdef FWRISC_FD_PIPE_BYPASS_EN
        byp = (m_cnt == 0) && fv && !fl;
`endif
        m_valid = (m_cnt != 0) || byp;
        if (byp) exp_head = {ins, c, pc};
        else if (m_cnt != 0) exp_head = exp_q[0];
        else exp_head = '0;
        check("fetch_ready_f", EW'(fetch_ready_f), EW'(m_ready));
        check("fetch_valid_d", EW'(fetch_valid_d), EW'(m_valid));
        check("count", EW'(count), EW'(m_cnt));
        check("head", {instr_d, instr_c_d, pc_d}, exp_head);
        push = fv && m_ready && !fl;
        pop  = m_valid && dr && !fl;
        @(posedge clock);
        #1;
        if (fl) begin
            exp_q.delete();
        end else if (!(byp && dr)) begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back({ins, c, pc});
        end
        m_cnt = exp_q.size();
    endtask

    task automatic idle(input logic dr);
        step(1'b0, 32'h0, 1'b0, 32'h0, dr, 1'b0);
    endtask

    initial begin
        reset_n        = 1'b0;
        flush          = 1'b0;
        fetch_valid_f  = 1'b0;
        instr_f        = '0;
        instr_c_f      = 1'b0;
        pc_f           = '0;
        decode_ready_d = 1'b0;

        phase = "reset";
        #12;
        check("count", EW'(count), EW'(0));
        check("fetch_valid_d", EW'(fetch_valid_d), EW'(0));
        check("fetch_ready_f", EW'(fetch_ready_f), EW'(1));
        check("instr_d", EW'(instr_d), EW'(0));
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        phase = "first_push";
        step(1'b1, 32'h00000013, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h00100093, 1'b1, 32'h4, 1'b0, 1'b0);
        idle(1'b0);

        phase = "reset_mid";
        fetch_valid_f = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("count", EW'(count), EW'(0));
        check("fetch_valid_d", EW'(fetch_valid_d), EW'(0));
        check("instr_d", EW'(instr_d), EW'(0));
        check("pc_d", EW'(pc_d), EW'(0));
        check("fetch_ready_f", EW'(fetch_ready_f), EW'(1));
        exp_q.delete();
        m_cnt = 0;
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        phase = "fill";
        step(1'b1, 32'h00000013, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h00100093, 1'b0, 32'h4, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 1'b0, 32'h8, 1'b0, 1'b0);
        step(1'b1, 32'h00300193, 1'b1, 32'hC, 1'b0, 1'b0);

        phase = "full_pop";
        step(1'b1, 32'h00400213, 1'b0, 32'h10, 1'b1, 1'b0);
        step(1'b1, 32'h00400213, 1'b0, 32'h10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        phase = "stream";
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h00000013 + 32'(i << 7), i[0], 32'(i * 4), 1'b1, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        phase = "flush";
        step(1'b1, 32'h11111111, 1'b0, 32'h20, 1'b0, 1'b0);
        step(1'b1, 32'h22222222, 1'b1, 32'h24, 1'b0, 1'b0);
        step(1'b1, 32'h33333333, 1'b0, 32'h28, 1'b0, 1'b0);
        step(1'b1, 32'h44444444, 1'b0, 32'h200, 1'b1, 1'b1);
        step(1'b1, 32'h55555555, 1'b0, 32'h100, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        phase = "empty_push_pop";
        step(1'b1, 32'h00A00513, 1'b0, 32'h300, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        phase = "random";
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 32'h400 + 32'(i * 4), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
